stream_max_pool: RTL and testbench

- Streaming K x K, stride-K max-pooling engine for the CNN feature-map path.
- Accepts raster-order pixels (NUM_CH channel lanes in parallel) over a valid/ready handshake.
- Keeps per-column partial maxima in an internal line buffer and emits one pooled pixel per window, with an end-of-frame marker.
- Successor to the fixed 2x2 single-channel pooler: window size, image size and channel count are parametrised, and it adds flow control and frame tracking.

---
 rtl/stream_max_pool_pkg.sv | 39 +++
 rtl/stream_max_pool_if.sv | 33 +++
 rtl/stream_max_pool_line_buf.sv | 38 +++
 rtl/stream_max_pool.sv | 167 ++++++++++++++++
 tb/tb_stream_max_pool.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_max_pool_pkg.sv
// -----------------------------------------------------------------------------
// max_pool_pkg
// Shared types and helpers for the streaming max-pool engine.
//   PIX_W        : widest lane the compare helper handles (19 bits).
//   DEF_*        : default geometry of the pooler.
//   OUT_W/OUT_H  : pooled image size for the default geometry.
//   cnt_w()      : counter width for a 0..n-1 counter (never 0 bits).
//   max2()       : lane maximum; two's-complement when
//                  STREAM_MAX_POOL_SIGNED_EN is defined, unsigned otherwise.
// -----------------------------------------------------------------------------
package max_pool_pkg;

  localparam int PIX_W      = 19;
  localparam int DEF_NUM_CH = 1;
  localparam int DEF_POOL_K = 2;
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OUT_W    = DEF_IMG_W / DEF_POOL_K;
  localparam int OUT_H    = DEF_IMG_H / DEF_POOL_K;
  localparam int OUT_W_CW = cnt_w(OUT_W);
  localparam int OUT_H_CW = cnt_w(OUT_H);

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [DEF_NUM_CH-1:0] vec_t;

  function automatic pix_t max2(input pix_t a, input pix_t b);
`ifdef STREAM_MAX_POOL_SIGNED_EN
    return ($signed(a) >= $signed(b)) ? a : b;
`else
    return (a >= b) ? a : b;
`endif
  endfunction

endpackage

// File: rtl/stream_max_pool_if.sv
// -----------------------------------------------------------------------------
// stream_max_pool_if
// Input and output streams of the max-pool engine.
//   pool_in_valid/ready/data    : raster-order pixels, NUM_CH lanes per beat
//   pool_out_valid/ready/data   : pooled pixels
//   pool_out_last               : marks the final pooled pixel of a frame
// Handshake: a beat transfers on a rising clock edge where valid && ready;
// the source holds valid and data stable until that edge, and ready may
// depend combinationally on the sink's state but never on valid.
// Modports: master = stream source/sink (testbench side), slave = pooler.
// -----------------------------------------------------------------------------
interface stream_max_pool_if #(
  parameter int OPERAND_WDTH = 19,
  parameter int NUM_CH       = 1
);
  logic                                    pool_in_valid;
  logic                                    pool_in_ready;
  logic [NUM_CH-1:0][OPERAND_WDTH-1:0]     pool_in_data;
  logic                                    pool_out_valid;
  logic                                    pool_out_ready;
  logic [NUM_CH-1:0][OPERAND_WDTH-1:0]     pool_out_data;
  logic                                    pool_out_last;

  modport master (
    output pool_in_valid, pool_in_data, pool_out_ready,
    input  pool_in_ready, pool_out_valid, pool_out_data, pool_out_last
  );

  modport slave (
    input  pool_in_valid, pool_in_data, pool_out_ready,
    output pool_in_ready, pool_out_valid, pool_out_data, pool_out_last
  );
endinterface

// File: rtl/stream_max_pool_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// Partial-maximum line buffer: one word of NUM_CH lanes per pooled column.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write column
//   wdata  : write word (all lanes)
//   raddr  : read column (asynchronous read)
//   rdata  : read word
// Contents are not reset; every column is written on the top window row
// before it is read back.
// -----------------------------------------------------------------------------
module pool_line_buf #(
  parameter int OPERAND_WDTH = 19,
  parameter int NUM_CH       = 1,
  parameter int DEPTH        = 14,
  parameter int ADDR_W       = 4
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   waddr,
  input  logic [NUM_CH-1:0][OPERAND_WDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]                   raddr,
  output logic [NUM_CH-1:0][OPERAND_WDTH-1:0] rdata
);

  logic [NUM_CH*OPERAND_WDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_max_pool.sv
// -----------------------------------------------------------------------------
// stream_max_pool
// Streaming POOL_K x POOL_K, stride-POOL_K max pooling over raster-order
// pixels with NUM_CH parallel lanes.
// Ports:
//   pool_clk : clock, rising edge
//   pool_rst : synchronous active-high reset
//   bus      : stream_max_pool_if.slave (input stream, pooled output stream)
// Build option: define STREAM_MAX_POOL_SIGNED_EN for two's-complement
// compares; the default build compares unsigned magnitudes.
// Datapath: hacc folds a window row horizontally, the line buffer folds rows
// vertically per pooled column, and the bottom-right pixel of each window
// loads the output register, so a result appears one cycle after that pixel.
// -----------------------------------------------------------------------------
module stream_max_pool
  import max_pool_pkg::*;
#(
  parameter int OPERAND_WDTH = 19,
  parameter int NUM_CH       = 1,
  parameter int POOL_K       = 2,
  parameter int IMG_W        = 28,
  parameter int IMG_H        = 28
) (
  input logic               pool_clk,
  input logic               pool_rst,
  stream_max_pool_if.slave  bus
);

  localparam int N_OCOL = IMG_W / POOL_K;
  localparam int N_OROW = IMG_H / POOL_K;
  localparam int WC_W   = cnt_w(POOL_K);
  localparam int OC_W   = cnt_w(N_OCOL);
  localparam int OR_W   = cnt_w(N_OROW);

  if ((IMG_W % POOL_K) != 0) begin : g_bad_img_w
    $error("stream_max_pool: IMG_W must be a multiple of POOL_K");
  end
  if ((IMG_H % POOL_K) != 0) begin : g_bad_img_h
    $error("stream_max_pool: IMG_H must be a multiple of POOL_K");
  end
  if (POOL_K < 2 || POOL_K > 4) begin : g_bad_k
    $error("stream_max_pool: POOL_K must be in 2..4");
  end
  if (OPERAND_WDTH > PIX_W) begin : g_bad_w
    $error("stream_max_pool: OPERAND_WDTH exceeds the compare lane width");
  end

  typedef logic [OPERAND_WDTH-1:0] lane_t;
  typedef lane_t [NUM_CH-1:0]      lanes_t;

  // Lanes narrower than the shared compare width are extended according to
  // the compare mode so the package helper orders them correctly.
  function automatic lane_t lane_max(input lane_t a, input lane_t b);
`ifdef STREAM_MAX_POOL_SIGNED_EN
    return lane_t'(max2(pix_t'($signed(a)), pix_t'($signed(b))));
`else
    return lane_t'(max2(pix_t'(a), pix_t'(b)));
`endif
  endfunction

  logic [WC_W-1:0] wcol;
  logic [WC_W-1:0] wrow;
  logic [OC_W-1:0] ocol;
  logic [OR_W-1:0] orow;

  lanes_t hacc;
  lanes_t h_new;
  lanes_t pb_rd;
  lanes_t vert;

  logic accept;
  logic wcol_end;
  logic ocol_end;
  logic wrow_end;
  logic orow_end;
  logic win_done;
  logic load;
  logic pb_we;

  logic   out_valid;
  logic   out_last;
  lanes_t out_data;

  // No bubble: a held result that is being taken this cycle frees the slot.
  assign bus.pool_in_ready = !out_valid || bus.pool_out_ready;
  assign accept            = bus.pool_in_valid && bus.pool_in_ready;

  assign wcol_end = (wcol == WC_W'(POOL_K - 1));
  assign wrow_end = (wrow == WC_W'(POOL_K - 1));
  assign ocol_end = (ocol == OC_W'(N_OCOL - 1));
  assign orow_end = (orow == OR_W'(N_OROW - 1));

  assign win_done = accept && wcol_end;
  assign pb_we    = win_done && !wrow_end;
  assign load     = win_done && wrow_end;

  // h_new is the running row maximum including the current beat; at the
  // last window column it is the window-row value v.
  always_comb begin
    h_new = '0;
    vert  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      h_new[c] = (wcol == '0) ? bus.pool_in_data[c]
                              : lane_max(hacc[c], bus.pool_in_data[c]);
      vert[c]  = (wrow == '0) ? h_new[c] : lane_max(pb_rd[c], h_new[c]);
    end
  end

  always_ff @(posedge pool_clk) begin
    if (pool_rst) begin
      wcol <= '0;
      ocol <= '0;
      wrow <= '0;
      orow <= '0;
      hacc <= '0;
    end else if (accept) begin
      hacc <= h_new;
      wcol <= wcol_end ? '0 : wcol + WC_W'(1);
      if (wcol_end) begin
        ocol <= ocol_end ? '0 : ocol + OC_W'(1);
        if (ocol_end) begin
          wrow <= wrow_end ? '0 : wrow + WC_W'(1);
          if (wrow_end) begin
            orow <= orow_end ? '0 : orow + OR_W'(1);
          end
        end
      end
    end
  end

  pool_line_buf #(
    .OPERAND_WDTH (OPERAND_WDTH),
    .NUM_CH       (NUM_CH),
    .DEPTH        (N_OCOL),
    .ADDR_W       (OC_W)
  ) u_line_buf (
    .clk   (pool_clk),
    .we    (pb_we),
    .waddr (ocol),
    .wdata (vert),
    .raddr (ocol),
    .rdata (pb_rd)
  );

  // A new result always wins over clearing: load only happens when the slot
  // is empty or being drained this same cycle.
  always_ff @(posedge pool_clk) begin
    if (pool_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= vert;
      out_last  <= ocol_end && orow_end;
    end else if (out_valid && bus.pool_out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end
  end

  assign bus.pool_out_valid = out_valid;
  assign bus.pool_out_data  = out_data;
  assign bus.pool_out_last  = out_last;

endmodule

// File: tb/tb_stream_max_pool.sv
// -----------------------------------------------------------------------------
// tb_stream_max_pool
// Three pooler instances sharing clock and reset:
//   u4  : 4x4 image,  K=2, 1 lane
//   u3  : 6x3 image,  K=3, 2 lanes
//   u28 : 28x28 image, K=2, 1 lane
// Accepted outputs are captured on the falling edge into per-instance queues
// and compared against hand-computed or window-model expectations.
// -----------------------------------------------------------------------------
module tb_stream_max_pool;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  stream_max_pool_if #(.OPERAND_WDTH(19), .NUM_CH(1)) bus4 ();
  stream_max_pool_if #(.OPERAND_WDTH(19), .NUM_CH(2)) bus3 ();
  stream_max_pool_if #(.OPERAND_WDTH(19), .NUM_CH(1)) bus28 ();

  stream_max_pool #(.OPERAND_WDTH(19), .NUM_CH(1), .POOL_K(2), .IMG_W(4), .IMG_H(4))
    u4 (.pool_clk(clk), .pool_rst(rst), .bus(bus4.slave));
  stream_max_pool #(.OPERAND_WDTH(19), .NUM_CH(2), .POOL_K(3), .IMG_W(6), .IMG_H(3))
    u3 (.pool_clk(clk), .pool_rst(rst), .bus(bus3.slave));
  stream_max_pool #(.OPERAND_WDTH(19), .NUM_CH(1), .POOL_K(2), .IMG_W(28), .IMG_H(28))
    u28 (.pool_clk(clk), .pool_rst(rst), .bus(bus28.slave));

`ifdef STREAM_MAX_POOL_SIGNED_EN
  localparam logic [18:0] MIXED_MAX = 19'd2;
`else
  localparam logic [18:0] MIXED_MAX = 19'h7FFFF;
`endif

  // ---------------- capture of accepted outputs ----------------
  logic [19:0] got4_q[$];
  logic [38:0] got3_q[$];
  logic [19:0] got28_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus4.pool_out_valid && bus4.pool_out_ready)
        got4_q.push_back({bus4.pool_out_last, bus4.pool_out_data[0]});
      if (bus3.pool_out_valid && bus3.pool_out_ready)
        got3_q.push_back({bus3.pool_out_last, bus3.pool_out_data[1], bus3.pool_out_data[0]});
      if (bus28.pool_out_valid && bus28.pool_out_ready)
        got28_q.push_back({bus28.pool_out_last, bus28.pool_out_data[0]});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got4_q.delete();
    got3_q.delete();
    got28_q.delete();
  endtask

  task automatic d4_send(input logic [18:0] v);
    int k;
    k = 0;
    bus4.pool_in_valid   = 1'b1;
    bus4.pool_in_data[0] = v;
    @(negedge clk);
    while (!bus4.pool_in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!bus4.pool_in_ready) begin
      n_checks++;
      $display("FAIL d4_send: in_ready stuck at %0b, required 1", bus4.pool_in_ready);
    end
    @(posedge clk); #1;
    bus4.pool_in_valid = 1'b0;
  endtask

  task automatic d3_send(input logic [18:0] c0, input logic [18:0] c1);
    int k;
    k = 0;
    bus3.pool_in_valid   = 1'b1;
    bus3.pool_in_data[0] = c0;
    bus3.pool_in_data[1] = c1;
    @(negedge clk);
    while (!bus3.pool_in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!bus3.pool_in_ready) begin
      n_checks++;
      $display("FAIL d3_send: in_ready stuck at %0b, required 1", bus3.pool_in_ready);
    end
    @(posedge clk); #1;
    bus3.pool_in_valid = 1'b0;
  endtask

  task automatic d28_send(input logic [18:0] v);
    int k;
    k = 0;
    bus28.pool_in_valid   = 1'b1;
    bus28.pool_in_data[0] = v;
    @(negedge clk);
    while (!bus28.pool_in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!bus28.pool_in_ready) begin
      n_checks++;
      $display("FAIL d28_send: in_ready stuck at %0b, required 1", bus28.pool_in_ready);
    end
    @(posedge clk); #1;
    bus28.pool_in_valid = 1'b0;
  endtask

  function automatic logic [18:0] ref_max(input logic [18:0] a, input logic [18:0] b);
`ifdef STREAM_MAX_POOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data} !== 21'd0)
      $display("FAIL reset_u4_out: got v=%0b l=%0b d=%0h, required 0/0/0",
               bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data);
    else n_pass++;
    n_checks++;
    if ({bus3.pool_out_valid, bus3.pool_out_last, bus3.pool_out_data} !== 40'd0)
      $display("FAIL reset_u3_out: got v=%0b l=%0b d=%0h, required 0/0/0",
               bus3.pool_out_valid, bus3.pool_out_last, bus3.pool_out_data);
    else n_pass++;
    n_checks++;
    if ({bus28.pool_out_valid, bus28.pool_out_last, bus28.pool_out_data} !== 21'd0)
      $display("FAIL reset_u28_out: got v=%0b l=%0b d=%0h, required 0/0/0",
               bus28.pool_out_valid, bus28.pool_out_last, bus28.pool_out_data);
    else n_pass++;
    n_checks++;
    if ({bus4.pool_in_ready, bus3.pool_in_ready, bus28.pool_in_ready} !== 3'b111)
      $display("FAIL reset_in_ready: got %b, required 111",
               {bus4.pool_in_ready, bus3.pool_in_ready, bus28.pool_in_ready});
    else n_pass++;
  endtask

  // 0..15 raster, output exactly one cycle after pixels 5, 7, 13, 15.
  task automatic test_raster();
    logic [20:0] exp;
    do_reset();
    bus4.pool_out_ready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      bus4.pool_in_valid   = 1'b1;
      bus4.pool_in_data[0] = 19'(p);
      @(posedge clk); #1;
      if (p == 5 || p == 7 || p == 13 || p == 15)
        exp = {1'b1, (p == 15), 19'(p)};
      else
        exp = 21'd0;
      n_checks++;
      if ({bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data[0]} !== exp)
        $display("FAIL raster_p%0d: got v/l/d=%0b/%0b/%0d, required %0b/%0b/%0d", p,
                 bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data[0],
                 exp[20], exp[19], exp[18:0]);
      else n_pass++;
    end
    bus4.pool_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [19:0] exp_q[$];
    do_reset();
    bus4.pool_out_ready = 1'b1;
    for (int p = 0; p < 6; p++) d4_send(19'(p));
    bus4.pool_out_ready  = 1'b0;
    bus4.pool_in_valid   = 1'b1;
    bus4.pool_in_data[0] = 19'd6;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus4.pool_in_ready, bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data[0]}
          !== {1'b0, 1'b1, 1'b0, 19'd5})
        $display("FAIL stall_hold_%0d: got rdy/v/l/d=%0b/%0b/%0b/%0d, required 0/1/0/5", i,
                 bus4.pool_in_ready, bus4.pool_out_valid, bus4.pool_out_last,
                 bus4.pool_out_data[0]);
      else n_pass++;
    end
    bus4.pool_out_ready = 1'b1;
    for (int p = 6; p < 16; p++) d4_send(19'(p));
    exp_q = '{{1'b0, 19'd5}, {1'b0, 19'd7}, {1'b0, 19'd13}, {1'b1, 19'd15}};
    for (int k = 0; k < 50 && got4_q.size() < 4; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_checks++;
    if (got4_q.size() !== 4)
      $display("FAIL stall_count: got %0d outputs, required 4", got4_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got4_q[i] !== exp_q[i])
        $display("FAIL stall_out_%0d: got %h, required %h", i, got4_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  // 6x3, K=3, ch0 = index, ch1 = 100 - index.
  task automatic test_multichannel();
    logic [38:0] exp_q[$];
    do_reset();
    bus3.pool_out_ready = 1'b1;
    for (int i = 0; i < 18; i++) d3_send(19'(i), 19'(100 - i));
    exp_q = '{{1'b0, 19'd100, 19'd14}, {1'b1, 19'd97, 19'd17}};
    for (int k = 0; k < 50 && got3_q.size() < 2; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_checks++;
    if (got3_q.size() !== 2)
      $display("FAIL mc_count: got %0d outputs, required 2", got3_q.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got3_q[i] !== exp_q[i])
        $display("FAIL mc_out_%0d: got %h, required %h", i, got3_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  // Windows {-3,2,-1,-7} and {-3,-9,-4,-5}; lower half all zero.
  task automatic test_signed();
    logic [18:0] px [16];
    logic [19:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 16; i++) px[i] = 19'd0;
    px[0] = -19'sd3; px[1] = 19'sd2;  px[4] = -19'sd1; px[5] = -19'sd7;
    px[2] = -19'sd3; px[3] = -19'sd9; px[6] = -19'sd4; px[7] = -19'sd5;
    bus4.pool_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) d4_send(px[i]);
    exp_q = '{{1'b0, MIXED_MAX}, {1'b0, 19'h7FFFD}, {1'b0, 19'd0}, {1'b1, 19'd0}};
    for (int k = 0; k < 50 && got4_q.size() < 4; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_checks++;
    if (got4_q.size() !== 4)
      $display("FAIL sign_count: got %0d outputs, required 4", got4_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got4_q[i] !== exp_q[i])
        $display("FAIL sign_out_%0d: got %h, required %h", i, got4_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] exp_q[$];
    do_reset();
    bus4.pool_out_ready = 1'b0;
    for (int p = 0; p < 6; p++) d4_send(19'(p));
    n_checks++;
    if ({bus4.pool_out_valid, bus4.pool_out_data[0]} !== {1'b1, 19'd5})
      $display("FAIL midrst_pending: got v/d=%0b/%0d, required 1/5",
               bus4.pool_out_valid, bus4.pool_out_data[0]);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data[0]} !== 21'd0)
      $display("FAIL midrst_drop: got v/l/d=%0b/%0b/%0d, required 0/0/0",
               bus4.pool_out_valid, bus4.pool_out_last, bus4.pool_out_data[0]);
    else n_pass++;
    rst = 1'b0;
    got4_q.delete();
    bus4.pool_out_ready = 1'b1;
    for (int p = 0; p < 16; p++) d4_send(19'(p));
    exp_q = '{{1'b0, 19'd5}, {1'b0, 19'd7}, {1'b0, 19'd13}, {1'b1, 19'd15}};
    for (int k = 0; k < 50 && got4_q.size() < 4; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_checks++;
    if (got4_q.size() !== 4)
      $display("FAIL midrst_count: got %0d outputs, required 4", got4_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got4_q[i] !== exp_q[i])
        $display("FAIL midrst_out_%0d: got %h, required %h", i, got4_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  // Two 28x28 frames with random input gaps and random output stalls.
  task automatic test_back_to_back();
    logic [18:0] img [2][784];
    logic [19:0] exp_q[$];
    logic [18:0] m;
    bit          drv_done;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 784; i++) img[f][i] = 19'($urandom_range(0, 19'h7FFFF));
      for (int oy = 0; oy < 14; oy++) begin
        for (int ox = 0; ox < 14; ox++) begin
          m = img[f][(2 * oy) * 28 + 2 * ox];
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              m = ref_max(m, img[f][(2 * oy + dy) * 28 + 2 * ox + dx]);
          exp_q.push_back({(oy == 13 && ox == 13), m});
        end
      end
    end
    drv_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          for (int i = 0; i < 784; i++) begin
            if ($urandom_range(0, 1) == 1) begin
              @(posedge clk); #1;
            end
            d28_send(img[f][i]);
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          bus28.pool_out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
      end
    join
    bus28.pool_out_ready = 1'b1;
    for (int k = 0; k < 2000 && got28_q.size() < 392; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_checks++;
    if (got28_q.size() !== 392)
      $display("FAIL b2b_count: got %0d outputs, required 392", got28_q.size());
    else n_pass++;
    for (int i = 0; i < 392; i++) begin
      n_checks++;
      if (got28_q[i] !== exp_q[i])
        $display("FAIL b2b_out_%0d: got %h, required %h", i, got28_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    bus4.pool_in_valid   = 1'b0;
    bus4.pool_in_data    = '0;
    bus4.pool_out_ready  = 1'b1;
    bus3.pool_in_valid   = 1'b0;
    bus3.pool_in_data    = '0;
    bus3.pool_out_ready  = 1'b1;
    bus28.pool_in_valid  = 1'b0;
    bus28.pool_in_data   = '0;
    bus28.pool_out_ready = 1'b1;

    test_reset();
    test_raster();
    test_backpressure();
    test_multichannel();
    test_signed();
    test_mid_reset();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
